ps2_mouse_init_ctrl: RTL and testbench

//  Sequences the PS/2 host transceiver (byte tx/rx engine) through the mouse power-up handshake.

---
 rtl/ps2_mouse_init_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_ps2_mouse_init_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_init_ctrl.sv
// PS/2 mouse bring-up sequencer (FF/FA/AA/00/F4/FA) feeding a 3-byte stream packet assembler.
// One-cycle registered response to tx_done/rx_done; no backpressure, transceiver pulses are consumed as they arrive.
module ps2_mouse_init_ctrl #(
  parameter int TIMEOUT_CYCLES = 25_000_000,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  output logic [7:0] tx_data,
  output logic       tx_write,
  input  logic       tx_done,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       STREAM,
  output logic       FAIL,
  output logic [1:0] retries,
  output logic       pkt_valid,
  output logic [7:0] pkt_b0,
  output logic [7:0] pkt_b1,
  output logic [7:0] pkt_b2
);

  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]      RETRY_MAX = 2'(MAX_RETRIES);

  localparam logic [7:0] CMD_RST = 8'hFF;
  localparam logic [7:0] CMD_EN  = 8'hF4;
  localparam logic [7:0] RSP_ACK = 8'hFA;
  localparam logic [7:0] RSP_BAT = 8'hAA;
  localparam logic [7:0] RSP_ID  = 8'h00;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SEND_RST,
    S_WAIT_ACK1,
    S_WAIT_BAT,
    S_WAIT_ID,
    S_SEND_EN,
    S_WAIT_ACK2,
    S_STREAM,
    S_FAIL
  } state_t;

  state_t          state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [1:0]      retries_q, retries_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_write_q, tx_write_d;
  logic [1:0]      idx_q, idx_d;
  logic [7:0]      s0_q, s0_d;
  logic [7:0]      s1_q, s1_d;
  logic [7:0]      pkt_b0_q, pkt_b0_d;
  logic [7:0]      pkt_b1_q, pkt_b1_d;
  logic [7:0]      pkt_b2_q, pkt_b2_d;
  logic            pkt_valid_q, pkt_valid_d;

  logic wd_exp;
  logic enter;
  logic err;

  assign wd_exp = (wd_q == WD_LAST);

  always_comb begin
    state_d     = state_q;
    retries_d   = retries_q;
    tx_data_d   = tx_data_q;
    idx_d       = idx_q;
    s0_d        = s0_q;
    s1_d        = s1_q;
    pkt_b0_d    = pkt_b0_q;
    pkt_b1_d    = pkt_b1_q;
    pkt_b2_d    = pkt_b2_q;
    pkt_valid_d = 1'b0;
    enter       = 1'b0;
    err         = 1'b0;

    case (state_q)
      S_IDLE, S_FAIL: begin
        if (start) begin
          state_d   = S_SEND_RST;
          retries_d = 2'd0;
          enter     = 1'b1;
        end
      end
      S_SEND_RST, S_SEND_EN: begin
        if (tx_done) begin
          state_d = (state_q == S_SEND_RST) ? S_WAIT_ACK1 : S_WAIT_ACK2;
          enter   = 1'b1;
        end else if (rx_done || wd_exp) begin
          err = 1'b1;
        end
      end
      S_WAIT_ACK1: begin
        if (rx_done) begin
          if (rx_data == RSP_ACK) begin
            state_d = S_WAIT_BAT;
            enter   = 1'b1;
          end else begin
            err = 1'b1;
          end
        end else if (wd_exp) begin
          err = 1'b1;
        end
      end
      S_WAIT_BAT: begin
        if (rx_done) begin
          if (rx_data == RSP_BAT) begin
            state_d = S_WAIT_ID;
            enter   = 1'b1;
          end else begin
            err = 1'b1;
          end
        end else if (wd_exp) begin
          err = 1'b1;
        end
      end
      S_WAIT_ID: begin
        if (rx_done) begin
          if (rx_data == RSP_ID) begin
            state_d = S_SEND_EN;
            enter   = 1'b1;
          end else begin
            err = 1'b1;
          end
        end else if (wd_exp) begin
          err = 1'b1;
        end
      end
      S_WAIT_ACK2: begin
        if (rx_done) begin
          if (rx_data == RSP_ACK) begin
            state_d = S_STREAM;
            idx_d   = 2'd0;
            enter   = 1'b1;
          end else begin
            err = 1'b1;
          end
        end else if (wd_exp) begin
          err = 1'b1;
        end
      end
      S_STREAM: begin
        // First byte must carry the always-one bit 3, otherwise we are mid-packet: drop and resync.
        if (rx_done) begin
          case (idx_q)
            2'd0: begin
              if (rx_data[3]) begin
                s0_d  = rx_data;
                idx_d = 2'd1;
              end
            end
            2'd1: begin
              s1_d  = rx_data;
              idx_d = 2'd2;
            end
            default: begin
              pkt_b0_d    = s0_q;
              pkt_b1_d    = s1_q;
              pkt_b2_d    = rx_data;
              pkt_valid_d = 1'b1;
              idx_d       = 2'd0;
            end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (err) begin
      enter = 1'b1;
      if (retries_q < RETRY_MAX) begin
        retries_d = retries_q + 2'd1;
        state_d   = S_SEND_RST;
      end else begin
        state_d = S_FAIL;
      end
    end

    // Self re-entry of SEND_RST on a retry must also re-issue the command.
    tx_write_d = enter && ((state_d == S_SEND_RST) || (state_d == S_SEND_EN));
    if (enter && (state_d == S_SEND_RST)) tx_data_d = CMD_RST;
    if (enter && (state_d == S_SEND_EN))  tx_data_d = CMD_EN;

    if (enter)         wd_d = '0;
    else if (wd_exp)   wd_d = wd_q;
    else               wd_d = wd_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      wd_q        <= '0;
      retries_q   <= 2'd0;
      tx_data_q   <= 8'h00;
      tx_write_q  <= 1'b0;
      idx_q       <= 2'd0;
      s0_q        <= 8'h00;
      s1_q        <= 8'h00;
      pkt_b0_q    <= 8'h00;
      pkt_b1_q    <= 8'h00;
      pkt_b2_q    <= 8'h00;
      pkt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      retries_q   <= retries_d;
      tx_data_q   <= tx_data_d;
      tx_write_q  <= tx_write_d;
      idx_q       <= idx_d;
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      pkt_b0_q    <= pkt_b0_d;
      pkt_b1_q    <= pkt_b1_d;
      pkt_b2_q    <= pkt_b2_d;
      pkt_valid_q <= pkt_valid_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_write  = tx_write_q;
  assign STREAM    = (state_q == S_STREAM);
  assign FAIL      = (state_q == S_FAIL);
  assign retries   = retries_q;
  assign pkt_valid = pkt_valid_q;
  assign pkt_b0    = pkt_b0_q;
  assign pkt_b1    = pkt_b1_q;
  assign pkt_b2    = pkt_b2_q;

endmodule

// File: tb/tb_ps2_mouse_init_ctrl.sv
// Directed bench for ps2_mouse_init_ctrl with a 1000-cycle watchdog.
module tb_ps2_mouse_init_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] tx_data;
  logic       tx_write;
  logic       tx_done;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       stream;
  logic       fail;
  logic [1:0] retries;
  logic       pkt_valid;
  logic [7:0] pkt_b0;
  logic [7:0] pkt_b1;
  logic [7:0] pkt_b2;

  int checks = 0;
  int errors = 0;
  int tx_cnt = 0;
  int pkt_cnt = 0;
  int n;
  int snap;

  ps2_mouse_init_ctrl #(.TIMEOUT_CYCLES(1000), .MAX_RETRIES(3)) dut (
    .CLK(clk), .RST(rst), .start(start),
    .tx_data(tx_data), .tx_write(tx_write), .tx_done(tx_done),
    .rx_data(rx_data), .rx_done(rx_done),
    .STREAM(stream), .FAIL(fail), .retries(retries),
    .pkt_valid(pkt_valid), .pkt_b0(pkt_b0), .pkt_b1(pkt_b1), .pkt_b2(pkt_b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_write) tx_cnt++;
    if (pkt_valid) pkt_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  // Waits for a tx_write pulse, checks the byte, then moves one cycle past it.
  task automatic wait_tx(input string tag, input logic [7:0] exp, input int budget, output int waited);
    waited = 0;
    while (!tx_write && waited < budget) begin
      tick();
      waited++;
    end
    check({tag, "_seen"}, tx_write, 1);
    check({tag, "_data"}, tx_data, exp);
    tick();
  endtask

  task automatic finish_handshake(input string tag);
    pulse_tx_done();
    send_rx(8'hFA);
    send_rx(8'hAA);
    send_rx(8'h00);
    wait_tx({tag, "_en"}, 8'hF4, 20, n);
    pulse_tx_done();
    send_rx(8'hFA);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; tx_done = 1'b0; rx_done = 1'b0; rx_data = 8'h00;
    tick(); tick();
    check("rst_tx_write", tx_write, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_stream", stream, 0);
    check("rst_fail", fail, 0);
    check("rst_retries", retries, 0);
    check("rst_pkt_valid", pkt_valid, 0);
    rst = 1'b1;
    repeat (5) tick();
    check("idle_no_tx", tx_cnt, 0);

    // 1: clean handshake
    pulse_start();
    wait_tx("t1_rst", 8'hFF, 0, n);
    finish_handshake("t1");
    check("t1_stream", stream, 1);
    check("t1_fail", fail, 0);
    check("t1_retries", retries, 0);
    check("t1_tx_cnt", tx_cnt, 2);

    // 2: packet assembly with resync
    send_rx(8'h08);
    send_rx(8'h05);
    check("t2_no_early_pkt", pkt_cnt, 0);
    send_rx(8'hFB);
    check("t2_pkt_valid", pkt_valid, 1);
    check("t2_b0", pkt_b0, 8'h08);
    check("t2_b1", pkt_b1, 8'h05);
    check("t2_b2", pkt_b2, 8'hFB);
    tick();
    check("t2_pulse_len", pkt_valid, 0);
    send_rx(8'h00);
    send_rx(8'h09);
    send_rx(8'h01);
    check("t2_resync_no_pkt", pkt_cnt, 1);
    check("t2_hold_b0", pkt_b0, 8'h08);
    send_rx(8'h02);
    check("t2_pkt2_valid", pkt_valid, 1);
    check("t2_pkt2_b0", pkt_b0, 8'h09);
    check("t2_pkt2_b1", pkt_b1, 8'h01);
    check("t2_pkt2_b2", pkt_b2, 8'h02);
    tick();
    check("t2_pkt_cnt", pkt_cnt, 2);
    pulse_start();
    check("t2_start_ignored", tx_cnt, 2);

    // 3: wrong BAT byte once
    do_reset();
    pulse_start();
    wait_tx("t3_rst", 8'hFF, 0, n);
    pulse_tx_done();
    send_rx(8'hFA);
    send_rx(8'hFC);
    check("t3_retries", retries, 1);
    wait_tx("t3_resend", 8'hFF, 0, n);
    finish_handshake("t3");
    check("t3_stream", stream, 1);
    check("t3_retries_kept", retries, 1);

    // 4: silent mouse, watchdog retries then FAIL
    do_reset();
    snap = tx_cnt;
    pulse_start();
    wait_tx("t4_ff0", 8'hFF, 0, n);
    for (int i = 1; i <= 3; i++) begin
      wait_tx("t4_ffr", 8'hFF, 1100, n);
      check("t4_interval", n, 999);
      check("t4_retries", retries, i);
    end
    repeat (998) tick();
    check("t4_not_yet_fail", fail, 0);
    tick();
    check("t4_fail", fail, 1);
    check("t4_stream", stream, 0);
    check("t4_retries_sat", retries, 3);
    check("t4_tx_cnt", tx_cnt - snap, 4);
    repeat (20) tick();
    check("t4_fail_sticky", fail, 1);
    pulse_start();
    check("t4_restart_retries", retries, 0);
    check("t4_restart_fail", fail, 0);
    wait_tx("t4_restart", 8'hFF, 0, n);

    // 6: rx FA on the exact expiry cycle of WAIT_ACK1
    pulse_tx_done();
    snap = tx_cnt;
    repeat (999) tick();
    send_rx(8'hFA);
    check("t6_retries", retries, 0);
    check("t6_no_resend", tx_cnt, snap);
    send_rx(8'hAA);
    send_rx(8'h00);
    wait_tx("t6_en", 8'hF4, 0, n);
    check("t6_en_latency", n, 0);

    // 5: reset during WAIT_BAT with a retry already consumed
    do_reset();
    pulse_start();
    wait_tx("t5_rst", 8'hFF, 0, n);
    pulse_tx_done();
    send_rx(8'hFA);
    send_rx(8'h55);
    wait_tx("t5_resend", 8'hFF, 0, n);
    pulse_tx_done();
    send_rx(8'hFA);
    check("t5_pre_retries", retries, 1);
    do_reset();
    check("t5_tx_write", tx_write, 0);
    check("t5_tx_data", tx_data, 8'h00);
    check("t5_retries", retries, 0);
    check("t5_stream", stream, 0);
    check("t5_fail", fail, 0);
    check("t5_pkt_b0", pkt_b0, 8'h00);
    snap = tx_cnt;
    repeat (1200) tick();
    check("t5_quiet", tx_cnt, snap);
    pulse_start();
    wait_tx("t5_start", 8'hFF, 0, n);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
